// File: rtl/munch_pkg.sv
// Shared types and constants for the munch host byte-bus responder.
// Holds the responder FSM states, register addresses and uio drive levels.
package munch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RDSETUP,
        RDACK,
        WAITLOW
    } host_state_t;

    localparam logic [1:0] ADDR_CFG0   = 2'd0;
    localparam logic [1:0] ADDR_CFG1   = 2'd1;
    localparam logic [1:0] ADDR_CFG2   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam logic [7:0] UIO_DRIVE   = 8'hFF;
    localparam logic [7:0] UIO_RELEASE = 8'h00;

endpackage

// File: rtl/munch_sync2.sv
// Single-bit synchronizer of configurable depth with synchronous active-low reset.
module munch_sync2 #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/munch_host_port.sv
// Four-phase strobe/acknowledge responder between the host pads and the munch core.
// Define MUNCH_HOST_READBACK_EN to enable the read data path onto the uio bus.
module munch_host_port
    import munch_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] CFG0_RST    = 8'h00,
    parameter logic [7:0] CFG1_RST    = 8'h01,
    parameter logic [7:0] CFG2_RST    = 8'hFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    output logic       host_ack,
    output logic [7:0] cfg0,
    output logic [7:0] cfg1,
    output logic [7:0] cfg2,
    input  logic       frame_tick,
    input  logic       core_busy
);

    host_state_t            state;
    logic                   stb_sync;
    logic [SYNC_STAGES-1:0] fill;
    logic                   low_seen;
    logic                   tick_sticky;
    logic                   start;
    logic                   rnw;
    logic [1:0]             addr;

    assign rnw  = ui_in[6];
    assign addr = ui_in[5:4];

    munch_sync2 #(.STAGES(SYNC_STAGES)) u_stb_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ui_in[7]),
        .q     (stb_sync)
    );

    // The synchronizer reads 0 until it has refilled after reset, so a low STB
    // only arms the edge detector once the chain holds real pad samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fill     <= '0;
            low_seen <= 1'b0;
        end else begin
            fill     <= {fill[SYNC_STAGES-2:0], 1'b1};
            low_seen <= ena && fill[SYNC_STAGES-1] && !stb_sync;
        end
    end

    assign start = ena && (state == IDLE) && stb_sync && low_seen;

`ifdef MUNCH_HOST_READBACK_EN
    logic [7:0] rd_value;
    logic       unused_bits;
    assign unused_bits = &{1'b0, ui_in[3:0]};

    always_comb begin
        rd_value = {6'b0, core_busy, tick_sticky};
        case (addr)
            ADDR_CFG0: rd_value = cfg0;
            ADDR_CFG1: rd_value = cfg1;
            ADDR_CFG2: rd_value = cfg2;
            default:   rd_value = {6'b0, core_busy, tick_sticky};
        endcase
    end
`else
    logic unused_bits;
    assign unused_bits = &{1'b0, ui_in[3:0], core_busy};
`endif

    // Outputs are loaded on entry to each state, which is what gives the
    // two-cycle write ACK and the data-before-ACK read setup.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            host_ack <= 1'b0;
            uio_oe   <= UIO_RELEASE;
            uio_out  <= 8'h00;
            cfg0     <= CFG0_RST;
            cfg1     <= CFG1_RST;
            cfg2     <= CFG2_RST;
        end else if (!ena) begin
            state    <= IDLE;
            host_ack <= 1'b0;
            uio_oe   <= UIO_RELEASE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (!rnw) begin
                            state    <= WRITE;
                            host_ack <= 1'b1;
                            case (addr)
                                ADDR_CFG0: cfg0 <= uio_in;
                                ADDR_CFG1: cfg1 <= uio_in;
                                ADDR_CFG2: cfg2 <= uio_in;
                                default:   ;
                            endcase
                        end else begin
`ifdef MUNCH_HOST_READBACK_EN
                            state   <= RDSETUP;
                            uio_out <= rd_value;
                            uio_oe  <= UIO_DRIVE;
`else
                            state    <= WAITLOW;
                            host_ack <= 1'b1;
`endif
                        end
                    end
                end
                WRITE: state <= WAITLOW;
                RDSETUP: begin
                    state    <= RDACK;
                    host_ack <= 1'b1;
                end
                // A falling STB already satisfies the WAITLOW exit, so release here.
                RDACK: begin
                    if (!stb_sync) begin
                        state    <= IDLE;
                        host_ack <= 1'b0;
                        uio_oe   <= UIO_RELEASE;
                    end
                end
                WAITLOW: begin
                    if (!stb_sync) begin
                        state    <= IDLE;
                        host_ack <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A new frame tick outranks a status read clearing the flag in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_sticky <= 1'b0;
        end else if (frame_tick) begin
            tick_sticky <= 1'b1;
`ifdef MUNCH_HOST_READBACK_EN
        end else if (start && rnw && (addr == ADDR_STATUS)) begin
            tick_sticky <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_munch_host_port.sv
// Self-checking bench for munch_host_port: directed protocol steps plus random
// host transactions checked against a register-level model of the host view.
module tb_munch_host_port;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       host_ack;
    logic [7:0] cfg0;
    logic [7:0] cfg1;
    logic [7:0] cfg2;
    logic       frame_tick;
    logic       core_busy;

    int pass_count  = 0;
    int fail_count  = 0;
    int check_count = 0;

    logic [7:0] cfg_model [0:2];
    logic       sticky_model;

`ifdef MUNCH_HOST_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    always #5 clk = ~clk;

    munch_host_port dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .ui_in      (ui_in),
        .uio_in     (uio_in),
        .uio_out    (uio_out),
        .uio_oe     (uio_oe),
        .host_ack   (host_ack),
        .cfg0       (cfg0),
        .cfg1       (cfg1),
        .cfg2       (cfg2),
        .frame_tick (frame_tick),
        .core_busy  (core_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic stb, input logic rnw,
                                 input logic [1:0] a, input logic [7:0] d);
        logic [3:0] junk;
        junk   = 4'($urandom);
        ui_in  = {stb, rnw, a, junk};
        uio_in = d;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %02h expected %02h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        cfg_model[0] = 8'h00;
        cfg_model[1] = 8'h01;
        cfg_model[2] = 8'hFF;
        sticky_model = 1'b0;
    endtask

    function automatic logic [7:0] model_read(input logic [1:0] a);
        if (a == 2'd3) return {6'b0, core_busy, sticky_model};
        return cfg_model[a];
    endfunction

    task automatic check_cfgs(input string tag);
        checkOutput({tag, "_cfg0"}, cfg0, cfg_model[0]);
        checkOutput({tag, "_cfg1"}, cfg1, cfg_model[1]);
        checkOutput({tag, "_cfg2"}, cfg2, cfg_model[2]);
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        tick();
        frame_tick   = 1'b0;
        sticky_model = 1'b1;
    endtask

    task automatic release_strobe(input string tag);
        applyStimulus(1'b0, 1'b0, 2'd0, 8'h00);
        tick();
        checkOutput({tag, "_ack_f0"}, {7'b0, host_ack}, 8'h01);
        tick();
        checkOutput({tag, "_ack_f1"}, {7'b0, host_ack}, 8'h01);
        tick();
        checkOutput({tag, "_ack_f2"}, {7'b0, host_ack}, 8'h00);
        checkOutput({tag, "_oe_f2"}, uio_oe, 8'h00);
    endtask

    task automatic host_write(input logic [1:0] a, input logic [7:0] d);
        applyStimulus(1'b1, 1'b0, a, d);
        tick();
        checkOutput("wr_ack_e0", {7'b0, host_ack}, 8'h00);
        tick();
        checkOutput("wr_ack_e1", {7'b0, host_ack}, 8'h00);
        tick();
        if (a != 2'd3) cfg_model[a] = d;
        checkOutput("wr_ack_e2", {7'b0, host_ack}, 8'h01);
        checkOutput("wr_oe_e2", uio_oe, 8'h00);
        check_cfgs("wr");
        release_strobe("wr");
    endtask

    task automatic host_read(input logic [1:0] a, input logic coincident_tick);
        logic [7:0] expected;
        expected = model_read(a);
        applyStimulus(1'b1, 1'b1, a, 8'($urandom));
        tick();
        checkOutput("rd_ack_e0", {7'b0, host_ack}, 8'h00);
        checkOutput("rd_oe_e0", uio_oe, 8'h00);
        tick();
        checkOutput("rd_ack_e1", {7'b0, host_ack}, 8'h00);
        if (coincident_tick) frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        if (coincident_tick) sticky_model = 1'b1;
        else if (READBACK && a == 2'd3) sticky_model = 1'b0;
        if (READBACK) begin
            checkOutput("rd_oe_e2", uio_oe, 8'hFF);
            checkOutput("rd_data_e2", uio_out, expected);
            checkOutput("rd_ack_e2", {7'b0, host_ack}, 8'h00);
            tick();
            checkOutput("rd_ack_e3", {7'b0, host_ack}, 8'h01);
            checkOutput("rd_data_e3", uio_out, expected);
        end else begin
            checkOutput("rd_ack_e2", {7'b0, host_ack}, 8'h01);
            checkOutput("rd_oe_e2", uio_oe, 8'h00);
            checkOutput("rd_data_e2", uio_out, 8'h00);
            tick();
            checkOutput("rd_oe_e3", uio_oe, 8'h00);
        end
        release_strobe("rd");
    endtask

    initial begin
        rst_n      = 1'b0;
        ena        = 1'b1;
        frame_tick = 1'b0;
        core_busy  = 1'b0;
        applyStimulus(1'b0, 1'b0, 2'd0, 8'h00);
        model_reset();
        tick();
        tick();
        checkOutput("rst_ack", {7'b0, host_ack}, 8'h00);
        checkOutput("rst_oe", uio_oe, 8'h00);
        checkOutput("rst_out", uio_out, 8'h00);
        check_cfgs("rst");
        rst_n = 1'b1;
        tick();
        tick();
        checkOutput("idle_ack", {7'b0, host_ack}, 8'h00);

        host_write(2'd1, 8'h5A);
        host_write(2'd2, 8'h3C);
        host_read(2'd2, 1'b0);

        pulse_tick();
        host_read(2'd3, 1'b0);
        host_read(2'd3, 1'b0);
        host_read(2'd3, 1'b1);
        host_read(2'd3, 1'b0);
        core_busy = 1'b1;
        host_read(2'd3, 1'b0);
        core_busy = 1'b0;

        host_write(2'd3, 8'hAA);
        check_cfgs("status_wr");

        // Drop ena while the read is acknowledged, then re-enable with STB still high.
        applyStimulus(1'b1, 1'b1, 2'd0, 8'h00);
        tick();
        tick();
        tick();
        if (READBACK) tick();
        checkOutput("ena_pre_ack", {7'b0, host_ack}, 8'h01);
        ena = 1'b0;
        tick();
        checkOutput("ena_off_ack", {7'b0, host_ack}, 8'h00);
        checkOutput("ena_off_oe", uio_oe, 8'h00);
        check_cfgs("ena_off");
        ena = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("ena_hold_ack", {7'b0, host_ack}, 8'h00);
            checkOutput("ena_hold_oe", uio_oe, 8'h00);
        end
        applyStimulus(1'b0, 1'b0, 2'd0, 8'h00);
        tick();
        tick();
        tick();
        host_write(2'd0, 8'h96);

        // Reset while a write is acknowledged, releasing it with STB still high.
        pulse_tick();
        applyStimulus(1'b1, 1'b0, 2'd0, 8'hC3);
        tick();
        tick();
        tick();
        cfg_model[0] = 8'hC3;
        checkOutput("rstmid_ack", {7'b0, host_ack}, 8'h01);
        check_cfgs("rstmid_pre");
        rst_n = 1'b0;
        tick();
        model_reset();
        checkOutput("rstmid_ack_rst", {7'b0, host_ack}, 8'h00);
        check_cfgs("rstmid_rst");
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("rstmid_hold_ack", {7'b0, host_ack}, 8'h00);
        end
        check_cfgs("rstmid_hold");
        applyStimulus(1'b0, 1'b0, 2'd0, 8'h00);
        tick();
        tick();
        tick();
        host_read(2'd3, 1'b0);

        for (int n = 0; n < 24; n++) begin
            logic [1:0] a;
            logic [7:0] d;
            a         = 2'($urandom_range(0, 3));
            d         = 8'($urandom);
            core_busy = 1'($urandom);
            if ($urandom_range(0, 3) == 0) pulse_tick();
            if ($urandom_range(0, 1) == 1) host_read(a, $urandom_range(0, 4) == 0);
            else host_write(a, d);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
        end
        check_cfgs("final");

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
